alu_cmd_ctrl: RTL and testbench

- Initiator side of the signed ALU operand/function interface.
- Accepts operation commands on a valid/ready port and drives the ALU's operand and function inputs from registers.
- Waits out the ALU's registered output latency, then captures the result and flag of the unit selected by the function code.
- Returns one response per command on a valid/ready port, with one operation in flight at a time, and keeps a wrapping completed-operation counter.

---
 rtl/alu_cmd_ctrl.sv | 157 +++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_ctrl.sv
// Command/response controller for the signed ALU: registers operands and function,
// waits out the ALU output latency, captures the selected unit's result and flag.
module alu_cmd_ctrl #(
    parameter int WIDTH   = 16,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WIDTH-1:0]     cmd_a,
    input  logic [WIDTH-1:0]     cmd_b,
    input  logic [3:0]           cmd_fun,
    output logic [WIDTH-1:0]     ALU_A,
    output logic [WIDTH-1:0]     ALU_B,
    output logic [3:0]           ALU_FUN,
    input  logic [2*WIDTH-1:0]   Arith_OUT,
    input  logic                 Carry_OUT,
    input  logic                 Arith_Flag,
    input  logic [WIDTH-1:0]     Logic_OUT,
    input  logic                 Logic_Flag,
    input  logic [WIDTH-1:0]     CMP_OUT,
    input  logic                 CMP_Flag,
    input  logic [WIDTH-1:0]     SHIFT_OUT,
    input  logic                 SHIFT_Flag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_result,
    output logic                 rsp_carry,
    output logic                 rsp_flag,
    output logic [1:0]           rsp_unit,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    localparam int WCW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE,
        RESP
    } state_t;

    state_t               state, state_nx;
    logic [WCW-1:0]       wait_cnt;
    logic                 accept;
    logic                 complete;
    logic [2*WIDTH-1:0]   sel_result;
    logic                 sel_carry;
    logic                 sel_flag;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    accept   = 1'b1;
                    state_nx = WAIT;
                end
            end
            // Leave when this edge's decrement takes the counter to zero.
            WAIT: begin
                if (wait_cnt == WCW'(1)) begin
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    complete = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        sel_result = '0;
        sel_carry  = 1'b0;
        sel_flag   = 1'b0;
        case (ALU_FUN[3:2])
            2'b00: begin
                sel_result = Arith_OUT;
                sel_carry  = Carry_OUT;
                sel_flag   = Arith_Flag;
            end
            2'b01: begin
                sel_result = {{WIDTH{Logic_OUT[WIDTH-1]}}, Logic_OUT};
                sel_flag   = Logic_Flag;
            end
            2'b10: begin
                sel_result = {{WIDTH{CMP_OUT[WIDTH-1]}}, CMP_OUT};
                sel_flag   = CMP_Flag;
            end
            default: begin
                sel_result = {{WIDTH{SHIFT_OUT[WIDTH-1]}}, SHIFT_OUT};
                sel_flag   = SHIFT_Flag;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            ALU_A      <= '0;
            ALU_B      <= '0;
            ALU_FUN    <= '0;
            wait_cnt   <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_flag   <= 1'b0;
            rsp_unit   <= '0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                ALU_A    <= cmd_a;
                ALU_B    <= cmd_b;
                ALU_FUN  <= cmd_fun;
                wait_cnt <= WCW'(ALU_LAT);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (state == CAPTURE) begin
                rsp_result <= sel_result;
                rsp_carry  <= sel_carry;
                rsp_flag   <= sel_flag;
                rsp_unit   <= ALU_FUN[3:2];
            end
            if (complete) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scoreboard bench for alu_cmd_ctrl with a registered (one-edge) behavioural ALU.
module tb_alu_cmd_ctrl;

    localparam int WIDTH   = 16;
    localparam int ALU_LAT = 1;
    localparam int CNT_W   = 3;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [WIDTH-1:0]     cmd_a;
    logic [WIDTH-1:0]     cmd_b;
    logic [3:0]           cmd_fun;
    logic [WIDTH-1:0]     ALU_A;
    logic [WIDTH-1:0]     ALU_B;
    logic [3:0]           ALU_FUN;
    logic [2*WIDTH-1:0]   Arith_OUT;
    logic                 Carry_OUT;
    logic                 Arith_Flag;
    logic [WIDTH-1:0]     Logic_OUT;
    logic                 Logic_Flag;
    logic [WIDTH-1:0]     CMP_OUT;
    logic                 CMP_Flag;
    logic [WIDTH-1:0]     SHIFT_OUT;
    logic                 SHIFT_Flag;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [2*WIDTH-1:0]   rsp_result;
    logic                 rsp_carry;
    logic                 rsp_flag;
    logic [1:0]           rsp_unit;
    logic                 busy;
    logic [CNT_W-1:0]     op_count;

    alu_cmd_ctrl #(
        .WIDTH   (WIDTH),
        .ALU_LAT (ALU_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_fun    (cmd_fun),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .ALU_FUN    (ALU_FUN),
        .Arith_OUT  (Arith_OUT),
        .Carry_OUT  (Carry_OUT),
        .Arith_Flag (Arith_Flag),
        .Logic_OUT  (Logic_OUT),
        .Logic_Flag (Logic_Flag),
        .CMP_OUT    (CMP_OUT),
        .CMP_Flag   (CMP_Flag),
        .SHIFT_OUT  (SHIFT_OUT),
        .SHIFT_Flag (SHIFT_Flag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_flag   (rsp_flag),
        .rsp_unit   (rsp_unit),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 CLK = ~CLK;

    // Every unit computes every cycle; carry comes from the adder whenever FUN[1:0]==00,
    // regardless of unit, so the controller's carry masking is visible.
    logic [2*WIDTH-1:0] ea, eb, ar_nx;
    logic [WIDTH:0]     sum_u;
    logic [WIDTH-1:0]   lo_nx, cm_nx, sh_nx;
    logic               sh_fl_nx;

    always_comb begin
        ea    = {{WIDTH{ALU_A[WIDTH-1]}}, ALU_A};
        eb    = {{WIDTH{ALU_B[WIDTH-1]}}, ALU_B};
        sum_u = {1'b0, ALU_A} + {1'b0, ALU_B};
        case (ALU_FUN[1:0])
            2'b00:   ar_nx = ea + eb;
            2'b01:   ar_nx = ea - eb;
            default: ar_nx = ea * eb;
        endcase
        case (ALU_FUN[1:0])
            2'b00:   lo_nx = ALU_A & ALU_B;
            2'b01:   lo_nx = ALU_A | ALU_B;
            2'b10:   lo_nx = ALU_A ^ ALU_B;
            default: lo_nx = ~(ALU_A & ALU_B);
        endcase
        if ($signed(ALU_A) > $signed(ALU_B)) cm_nx = WIDTH'(1);
        else if (ALU_A == ALU_B)             cm_nx = '0;
        else                                 cm_nx = '1;
        if (ALU_FUN[0]) begin
            sh_nx    = ALU_A << 1;
            sh_fl_nx = ALU_A[WIDTH-1];
        end else begin
            sh_nx    = {ALU_A[WIDTH-1], ALU_A[WIDTH-1:1]};
            sh_fl_nx = ALU_A[0];
        end
    end

    always_ff @(posedge CLK) begin
        Arith_OUT  <= ar_nx;
        Arith_Flag <= (ar_nx == '0);
        Carry_OUT  <= (ALU_FUN[1:0] == 2'b00) ? sum_u[WIDTH] : 1'b0;
        Logic_OUT  <= lo_nx;
        Logic_Flag <= (lo_nx == '0);
        CMP_OUT    <= cm_nx;
        CMP_Flag   <= (ALU_A == ALU_B);
        SHIFT_OUT  <= sh_nx;
        SHIFT_Flag <= sh_fl_nx;
    end

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [3:0]         fun;
        logic [2*WIDTH-1:0] res;
        logic               c;
        logic               f;
        logic [1:0]         u;
    } vec_t;

    typedef struct {
        logic [2*WIDTH-1:0] result;
        logic               carry;
        logic               flag;
        logic [1:0]         unit;
        int                 acc_cyc;
    } exp_t;

    exp_t             sb_q[$];
    int               checks    = 0;
    int               failures  = 0;
    int               cyc       = 0;
    int               rsp_total = 0;
    logic [CNT_W-1:0] exp_count = '0;
    vec_t             tbl[8];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                sb_q.delete();
                exp_count  = '0;
                prev_valid = 1'b0;
            end else begin
                check_val("op_count", 64'(op_count), 64'(exp_count));
                if (rsp_valid) begin
                    check_val("cmd_ready_in_resp", 64'(cmd_ready), 64'd0);
                end
                if (rsp_valid && !prev_valid) begin
                    if (sb_q.size() == 0) begin
                        check_val("spurious_rsp", 64'(rsp_valid), 64'd0);
                    end else begin
                        check_val("rsp_latency", 64'(cyc - sb_q[0].acc_cyc), 64'd2);
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    rsp_total++;
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check_val("rsp_result", 64'(rsp_result), 64'(e.result));
                        check_val("rsp_carry", 64'(rsp_carry), 64'(e.carry));
                        check_val("rsp_flag", 64'(rsp_flag), 64'(e.flag));
                        check_val("rsp_unit", 64'(rsp_unit), 64'(e.unit));
                    end
                    exp_count = exp_count + 1'b1;
                end
                prev_valid = rsp_valid && !rsp_ready;
            end
        end
    endtask

    task automatic send_cmd(input vec_t v);
        logic ok;
        @(negedge CLK);
        cmd_a     = v.a;
        cmd_b     = v.b;
        cmd_fun   = v.fun;
        cmd_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        check_val("cmd_accepted", 64'(ok), 64'd1);
        if (ok) begin
            @(posedge CLK);
            #1;
            sb_q.push_back('{result: v.res, carry: v.c, flag: v.f, unit: v.u, acc_cyc: cyc});
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (sb_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        check_val("drain", 64'(done), 64'd1);
    endtask

    task automatic check_zeroed(input string pfx);
        check_val({pfx, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check_val({pfx, "_busy"}, 64'(busy), 64'd0);
        check_val({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check_val({pfx, "_alu_a"}, 64'(ALU_A), 64'd0);
        check_val({pfx, "_alu_b"}, 64'(ALU_B), 64'd0);
        check_val({pfx, "_alu_fun"}, 64'(ALU_FUN), 64'd0);
        check_val({pfx, "_rsp_result"}, 64'(rsp_result), 64'd0);
        check_val({pfx, "_rsp_carry"}, 64'(rsp_carry), 64'd0);
        check_val({pfx, "_rsp_flag"}, 64'(rsp_flag), 64'd0);
        check_val({pfx, "_rsp_unit"}, 64'(rsp_unit), 64'd0);
        check_val({pfx, "_op_count"}, 64'(op_count), 64'd0);
    endtask

    initial begin
        vec_t s1, s2, drop, post;
        int   r0;
        logic seen;

        tbl[0] = '{16'd5,    16'd7,    4'b0000, 32'h0000000C, 1'b0, 1'b0, 2'd0};
        tbl[1] = '{16'd3,    16'd10,   4'b0001, 32'hFFFFFFF9, 1'b0, 1'b0, 2'd0};
        tbl[2] = '{16'd300,  16'hFF38, 4'b0010, 32'hFFFF15A0, 1'b0, 1'b0, 2'd0};
        tbl[3] = '{16'h00F0, 16'h0FF0, 4'b0100, 32'h000000F0, 1'b0, 1'b0, 2'd1};
        tbl[4] = '{16'hFFFF, 16'h0001, 4'b0000, 32'h00000000, 1'b1, 1'b1, 2'd0};
        tbl[5] = '{16'hFFFB, 16'h0007, 4'b1000, 32'hFFFFFFFF, 1'b0, 1'b0, 2'd2};
        tbl[6] = '{16'h8000, 16'h8000, 4'b1100, 32'hFFFFC000, 1'b0, 1'b0, 2'd3};
        tbl[7] = '{16'h8001, 16'h8001, 4'b0110, 32'h00000000, 1'b0, 1'b1, 2'd1};
        s1     = '{16'h8200, 16'h0034, 4'b0101, 32'hFFFF8234, 1'b0, 1'b0, 2'd1};
        s2     = '{16'h4001, 16'h0000, 4'b1101, 32'hFFFF8002, 1'b0, 1'b0, 2'd3};
        drop   = '{16'h1111, 16'h2222, 4'b0000, 32'h00003333, 1'b0, 1'b0, 2'd0};
        post   = '{16'h0042, 16'h0042, 4'b1000, 32'h00000000, 1'b0, 1'b1, 2'd2};

        RST       = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_fun   = '0;
        rsp_ready = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(posedge CLK);
        #1;
        check_zeroed("reset");
        RST = 1'b1;

        // Eight operations wrap the 3-bit completed-operation counter back to zero.
        for (int i = 0; i < 8; i++) begin
            send_cmd(tbl[i]);
        end
        drain();
        check_val("op_count_wrap", 64'(op_count), 64'd0);

        @(posedge CLK);
        #1;
        rsp_ready = 1'b0;
        fork
            begin
                send_cmd(s1);
                send_cmd(s2);
            end
            begin
                seen = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge CLK);
                    if (rsp_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check_val("stall_rsp_seen", 64'(seen), 64'd1);
                for (int i = 0; i < 5; i++) begin
                    @(negedge CLK);
                    check_val("stall_rsp_valid", 64'(rsp_valid), 64'd1);
                    check_val("stall_cmd_ready", 64'(cmd_ready), 64'd0);
                    check_val("stall_rsp_result", 64'(rsp_result), 64'h00000000FFFF8234);
                    check_val("stall_op_count", 64'(op_count), 64'd0);
                end
                @(posedge CLK);
                #1;
                rsp_ready = 1'b1;
            end
        join
        drain();
        check_val("op_count_after_stall", 64'(op_count), 64'd2);

        send_cmd(drop);
        r0  = rsp_total;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check_zeroed("wait_reset");
        RST = 1'b1;
        repeat (8) @(posedge CLK);
        #1;
        check_val("dropped_no_rsp", 64'(rsp_total), 64'(r0));
        check_val("dropped_sb_empty", 64'(sb_q.size()), 64'd0);

        send_cmd(post);
        drain();
        check_val("op_count_after_reset", 64'(op_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
